huffman_bit_packer: RTL
=======================

# huffman_bit_packer

- Parametrised variable-length code packer for the Deflate output path.
- Accepts one code per handshake: up to IN_W bits, MSB-first, right-aligned in `in_data`, length `in_len`.
- Concatenates codes into an ACC_W-bit accumulator and emits fixed OUT_W-bit words over a valid/ready stream.
- On end of block, flushes a final zero-padded partial word with a byte count; sits between the Huffman encoder and the output DMA/FIFO.

## Interface
- IN_W, 32: maximum code width per input beat.
- OUT_W, 64: output word width; multiple of 8, and OUT_W ≥ IN_W.
- ACC_W, 128: accumulator width; ACC_W ≥ OUT_W + IN_W.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  packer can accept a beat.
- in_data  in  IN_W  code bits, right-aligned; bits at or above `in_len` are ignored (masked).
- in_len  in  $clog2(IN_W+1)  code length 0..IN_W; values above IN_W saturate to IN_W.
- in_last  in  1  this beat ends the block and triggers a flush.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  OUT_W  packed bits; the oldest bit is at the MSB.
- out_bytes  out  $clog2(OUT_W/8+1)  valid bytes in `out_data`, counted from the MSB.
- out_last  out  1  final word of the block.

## Operation
- State:
  - `acc` (ACC_W bits): valid bits occupy `acc[fill-1:0]`; the oldest bit is at `acc[fill-1]`.
  - `fill` ($clog2(ACC_W+1) bits).
  - FSM: PACK or FLUSH.
- Accept (`in_valid && in_ready`):
  - acc ← (acc << len) | (in_data & mask(len)).
  - fill ← fill + len.
  - `len` = 0 is legal and leaves `acc` unchanged.
- Emit (`out_valid && out_ready`):
  - fill ← fill − OUT_W for a full word.
  - fill ← 0 for the final word.
- Simultaneous accept and emit in one cycle: fill ← fill + len − OUT_W. Both update `acc` in the same edge; emitted bits are dropped from the top.
- PACK:
  - in_ready = (fill ≤ ACC_W − IN_W).
  - out_valid = (fill ≥ OUT_W).
  - out_data = acc[fill-1 -: OUT_W].
  - out_bytes = OUT_W/8, out_last = 0.
  - Accepted `in_last` → FLUSH.
- FLUSH:
  - in_ready = 0, out_valid = 1.
  - fill ≥ OUT_W: emit a full word, as in PACK.
  - fill < OUT_W: emit the final word.
    - out_data = acc[fill-1:0] << (OUT_W − fill), zero-padded at the LSBs.
    - out_bytes = ceil(fill/8), out_last = 1.
  - Final-word handshake → PACK, with acc = 0 and fill = 0.
  - fill = 0 at end of block: emit one word with out_data = 0, out_bytes = 0, out_last = 1.
- Overflow is impossible under the in_ready rule; ACC_W ≥ OUT_W + IN_W guarantees forward progress.

## Timing
- Reset values: acc = 0, fill = 0, state = PACK, in_ready = 1, out_valid = 0, out_data = 0, out_bytes = 0, out_last = 0.
- Outputs are decoded from registered state only; there is no combinational path from in_* to out_*, nor from out_ready to in_ready.
- Latency: a beat accepted at edge N that makes fill ≥ OUT_W asserts out_valid after edge N.
- Throughput: one beat per cycle when out_ready = 1 and the average code length ≤ OUT_W per cycle.
- out_data, out_bytes and out_last are held stable while out_valid && !out_ready.
- Reset asserted mid-block: all state clears asynchronously, out_valid drops immediately, and partial bits are discarded.
- in_last with in_len = 0 is legal: its code bits are a no-op and it still triggers FLUSH.

## Configuration
- `HUFFMAN_BIT_PACKER_STATS_EN` defined:
  - Adds outputs `stat_bits` (32 bits: total code bits accepted) and `stat_words` (32 bits: words emitted, including final words).
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: those ports and counters are absent; all other behaviour is identical.

## Structure
- Package `huffman_bit_packer_pkg`:
  - State enum (PACK, FLUSH).
  - Width helper functions for the len, fill and out_bytes fields.
  - Default parameter constants.
- One sub-module, `bit_packer_stats`: the two saturating-free counters, instantiated only under the macro.

## Test plan
- Reset, then two beats (0xDEADBEEF, 32), (0xCAFEF00D, 32) → one word 0xDEADBEEFCAFEF00D, out_bytes = 8, out_last = 0.
- Beats (0b101, 3) then (0x1, 1, last=1) → final word 0xB000000000000000, out_bytes = 1, out_last = 1; FSM returns to PACK with fill = 0.
- Hold out_ready = 0 while streaming 32-bit codes → in_ready drops once fill = 128; the head word is held stable; releasing out_ready drains words in order with no loss.
- Beat (0xFFFFFFFF, 4) → only 4 one-bits enter; the upper 28 bits are masked. in_len = 40 is treated as 32.
- in_last on a (0, 0) beat with fill = 0 → a single word with out_bytes = 0, out_last = 1.
- Assert reset mid-FLUSH → out_valid = 0 immediately; the next block packs from empty. With STATS_EN, stat_bits and stat_words read 0.

Source files
------------

// File: rtl/huffman_bit_packer_pkg.sv
// Shared types, default sizes and width helpers for the Huffman bit packer.
`default_nettype none

package huffman_bit_packer_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 64;
  localparam int DEF_ACC_W = 128;

  typedef enum logic [0:0] {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic int len_w(input int in_w);
    return $clog2(in_w + 1);
  endfunction

  function automatic int fill_w(input int acc_w);
    return $clog2(acc_w + 1);
  endfunction

  function automatic int bytes_w(input int out_w);
    return $clog2(out_w / 8 + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/huffman_bit_packer_if.sv
// Code-in / word-out stream bundle; slave is the packer, master the surroundings.
`default_nettype none

interface huffman_bit_packer_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 64
) ();

  logic                                                in_valid;
  logic                                                in_ready;
  logic [IN_W-1:0]                                     in_data;
  logic [huffman_bit_packer_pkg::len_w(IN_W)-1:0]      in_len;
  logic                                                in_last;
  logic                                                out_valid;
  logic                                                out_ready;
  logic [OUT_W-1:0]                                    out_data;
  logic [huffman_bit_packer_pkg::bytes_w(OUT_W)-1:0]   out_bytes;
  logic                                                out_last;

  modport slave (
    input  in_valid, in_data, in_len, in_last, out_ready,
    output in_ready, out_valid, out_data, out_bytes, out_last
  );

  modport master (
    output in_valid, in_data, in_len, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_bytes, out_last
  );

endinterface

`default_nettype wire

// File: rtl/huffman_bit_packer_stats.sv
// Free-running, wrapping counters of accepted code bits and emitted words.
`default_nettype none

module bit_packer_stats #(
  parameter int LEN_W = 6
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_accept,
  input  wire logic [LEN_W-1:0] i_len,
  input  wire logic             i_emit,
  output logic [31:0]           o_stat_bits,
  output logic [31:0]           o_stat_words
);

  logic [31:0] r_bits;
  logic [31:0] r_words;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bits  <= '0;
      r_words <= '0;
    end else begin
      if (i_accept) r_bits  <= r_bits + 32'(i_len);
      if (i_emit)   r_words <= r_words + 32'd1;
    end
  end

  assign o_stat_bits  = r_bits;
  assign o_stat_words = r_words;

endmodule

`default_nettype wire

// File: rtl/huffman_bit_packer.sv
// Packs MSB-first variable-length codes into OUT_W-bit words, flushing a padded tail on in_last.
// Optional counters are enabled with HUFFMAN_BIT_PACKER_STATS_EN.
`default_nettype none

module huffman_bit_packer
  import huffman_bit_packer_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  huffman_bit_packer_if.slave bus
`ifdef HUFFMAN_BIT_PACKER_STATS_EN
  ,
  output logic [31:0]         o_stat_bits,
  output logic [31:0]         o_stat_words
`endif
);

  localparam int LEN_W   = len_w(IN_W);
  localparam int FILL_W  = fill_w(ACC_W);
  localparam int BYTES_W = bytes_w(OUT_W);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [FILL_W-1:0]  r_fill;

  logic [LEN_W-1:0]   w_len;
  logic [IN_W-1:0]    w_mask;
  logic [ACC_W-1:0]   w_acc_shift;
  logic [ACC_W-1:0]   w_aligned;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic               w_full;
  logic               w_final;
  logic               w_accept;
  logic               w_emit;

  assign w_len       = (bus.in_len > LEN_W'(IN_W)) ? LEN_W'(IN_W) : bus.in_len;
  assign w_mask      = ~({IN_W{1'b1}} << w_len);
  assign w_acc_shift = (r_acc << w_len) | ACC_W'(bus.in_data & w_mask);

  assign w_full      = (r_fill >= FILL_W'(OUT_W));
  assign w_final     = (r_state == FLUSH) && !w_full;

  assign bus.in_ready  = (r_state == PACK) && (r_fill <= FILL_W'(ACC_W - IN_W));
  assign bus.out_valid = (r_state == FLUSH) || w_full;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_emit        = bus.out_valid && bus.out_ready;

  // Left-justify the live bits so the oldest lands at the MSB; bits above fill fall off.
  assign w_aligned     = r_acc << (FILL_W'(ACC_W) - r_fill);
  assign bus.out_data  = bus.out_valid ? w_aligned[ACC_W-1 -: OUT_W] : '0;
  assign bus.out_bytes = !bus.out_valid ? '0 :
                         w_final ? BYTES_W'((r_fill + FILL_W'(7)) >> 3) :
                                   BYTES_W'(OUT_W / 8);
  assign bus.out_last  = w_final;

  assign w_fill_nxt = r_fill + (w_accept ? FILL_W'(w_len) : '0)
                             - (w_emit   ? FILL_W'(OUT_W) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PACK;
      r_acc   <= '0;
      r_fill  <= '0;
    end else begin
      case (r_state)
        PACK: begin
          if (w_accept) r_acc <= w_acc_shift;
          r_fill <= w_fill_nxt;
          if (w_accept && bus.in_last) r_state <= FLUSH;
        end
        FLUSH: begin
          if (w_emit) begin
            if (w_final) begin
              r_acc   <= '0;
              r_fill  <= '0;
              r_state <= PACK;
            end else begin
              r_fill  <= r_fill - FILL_W'(OUT_W);
            end
          end
        end
        default: r_state <= PACK;
      endcase
    end
  end

`ifdef HUFFMAN_BIT_PACKER_STATS_EN
  bit_packer_stats #(
    .LEN_W(LEN_W)
  ) u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_accept    (w_accept),
    .i_len       (w_len),
    .i_emit      (w_emit),
    .o_stat_bits (o_stat_bits),
    .o_stat_words(o_stat_words)
  );
`endif

endmodule

`default_nettype wire
